// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, the control bundle layout, the
// result/immediate source encodings and the Zbb unary imm12 constants.
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    localparam logic [2:0]  ZBB_FUNCT3    = 3'b001;
    localparam logic [11:0] ZBB_IMM_CLZ   = 12'h600;
    localparam logic [11:0] ZBB_IMM_CTZ   = 12'h601;
    localparam logic [11:0] ZBB_IMM_CPOP  = 12'h602;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic       zbb;
        logic       illegal;
    } ctrl_t;

    // True for the I-ALU encodings that Zbb uses for clz/ctz/cpop.
    function automatic logic is_zbb_unary(input logic [31:0] instr);
        logic [11:0] imm12;
        imm12 = instr[31:20];
        return (instr[6:0] == OP_IALU) && (instr[14:12] == ZBB_FUNCT3) &&
               ((imm12 == ZBB_IMM_CLZ) || (imm12 == ZBB_IMM_CTZ) ||
                (imm12 == ZBB_IMM_CPOP));
    endfunction

endpackage

// File: rtl/rv_ctrl_decoder.sv
// Combinational RV32I main decoder: raw instruction -> ctrl_t.
// Build option: define ZBB_DECODE_EN to decode clz/ctz/cpop; otherwise
// those encodings are flagged illegal.
module rv_ctrl_decoder
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [6:0] opcode;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    // Register specifiers do not affect the control bundle.
    assign unused_fields = ^{instr[19:15], instr[11:7]};

    // Opcode decode; illegal encodings zero every bit except illegal.
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_S;
            end
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = 2'b10;
            end
            OP_IALU: begin
                if (is_zbb_unary(instr)) begin
`ifdef ZBB_DECODE_EN
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = 2'b10;
                    ctrl.zbb       = 1'b1;
`else
                    ctrl.illegal   = 1'b1;
`endif
                end else begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.alu_op    = 2'b10;
                end
            end
            OP_BRANCH: begin
                ctrl.branch  = 1'b1;
                ctrl.alu_op  = 2'b01;
                ctrl.imm_src = IMM_B;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.imm_src    = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.jalr       = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            OP_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_IMM;
                ctrl.imm_src    = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_U;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
        // Compressed/reserved quadrants are never valid here.
        if (instr[1:0] != 2'b11) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_queue_stage.sv
// Registered decode stage: decodes fetched instructions and buffers
// {ctrl, instr, pc} in a DEPTH-entry FIFO between fetch and execute.
// Build option: ZBB_DECODE_EN (passed through to rv_ctrl_decoder).
module decode_queue_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output ctrl_t                      out_ctrl,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           illegal_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        ctrl_t            ctrl;
        logic [31:0]      instr;
        logic [XLEN-1:0]  pc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    ctrl_t           in_ctrl;
    logic            push;
    logic            pop;

    rv_ctrl_decoder u_dec (
        .instr (in_instr),
        .ctrl  (in_ctrl)
    );

    // in_ready looks only at registered level so it never depends on out_ready.
    assign in_ready  = !reset && (level_q < LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign out_ctrl      = mem_q[rd_ptr_q].ctrl;
    assign out_instr     = mem_q[rd_ptr_q].instr;
    assign out_pc        = mem_q[rd_ptr_q].pc;
    assign level         = level_q;
    assign illegal_count = cnt_q;

    // Next-state for storage, pointers, occupancy and the illegal counter.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{ctrl: in_ctrl, instr: in_instr, pc: in_pc};
                wr_ptr_d        = wr_ptr_q + 1'b1;
                if (in_ctrl.illegal && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // State registers; reset also clears storage so the head reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_decode_queue_stage.sv
// Scoreboard bench for decode_queue_stage (DEPTH=4, CNT_W=2).
module tb_decode_queue_stage;
    import decode_pkg::*;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        ctrl_t       c;
        logic [31:0] i;
        logic [31:0] p;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    ctrl_t       out_ctrl;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  level;
    logic [1:0]  illegal_count;

    ctrl_t exp_ctrl_in;
    exp_t  sb[$];
    exp_t  mon_e;
    int    mdl_lvl;
    int    mdl_cnt;
    int    vectors;
    int    miscompares;

    ctrl_t C_ADDI, C_LW, C_SW, C_ADD, C_BEQ, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL, C_CLZ;

    decode_queue_stage #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ctrl      (out_ctrl),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .level         (level),
        .illegal_count (illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t mk(input logic rw, input logic mw, input logic br,
                                 input logic j, input logic jr, input logic as,
                                 input logic [1:0] aop, input logic [1:0] rs,
                                 input logic [2:0] is, input logic z, input logic il);
        ctrl_t c;
        c.reg_write = rw; c.mem_write = mw; c.branch = br; c.jump = j;
        c.jalr = jr; c.alu_src = as; c.alu_op = aop; c.result_src = rs;
        c.imm_src = is; c.zbb = z; c.illegal = il;
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state();
        chk("level", 32'(level), 32'(mdl_lvl));
        chk("in_ready", 32'(in_ready), 32'(!reset && (mdl_lvl < DEPTH)));
        chk("illegal_count", 32'(illegal_count), 32'(mdl_cnt));
    endtask

    // Inputs change 1ns after the edge; checks happen 1ns after the next edge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input ctrl_t ec, input logic ordy, input logic fl);
        in_valid    = v;
        in_instr    = ins;
        in_pc       = pc;
        exp_ctrl_in = ec;
        out_ready   = ordy;
        flush       = fl;
        @(posedge clk);
        #1;
        chk_state();
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 32'h0, 32'h0, '0, ordy, 1'b0);
    endtask

    // Reference model: occupancy, counter and expected-output queue.
    always @(posedge clk) begin
        logic acc, pp;
        if (reset) begin
            mdl_lvl = 0;
            mdl_cnt = 0;
            sb.delete();
        end else if (flush) begin
            mdl_lvl = 0;
            sb.delete();
        end else begin
            acc = in_valid && (mdl_lvl < DEPTH);
            pp  = (mdl_lvl != 0) && out_ready;
            if (acc) begin
                sb.push_back('{c: exp_ctrl_in, i: in_instr, p: in_pc});
                if (exp_ctrl_in.illegal && mdl_cnt < CNT_MAX) mdl_cnt = mdl_cnt + 1;
            end
            mdl_lvl = mdl_lvl + int'(acc) - int'(pp);
        end
    end

    // Monitor: compare the head against the scoreboard whenever it is consumed.
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", 32'(out_valid), 32'(mdl_lvl != 0));
            if (out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pop_empty: got output pc %h expected none", out_pc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_ctrl", 32'(out_ctrl), 32'(mon_e.c));
                    chk("out_instr", out_instr, mon_e.i);
                    chk("out_pc", out_pc, mon_e.p);
                end
            end
        end
    end

    initial begin
        logic [31:0] ss_instr [4];
        ctrl_t       ss_ctrl  [4];
        int          ill_exp  [5];

        vectors = 0; miscompares = 0; mdl_lvl = 0; mdl_cnt = 0;
        C_ADDI  = mk(1,0,0,0,0,1,2'b10,2'b00,3'b000,0,0);
        C_LW    = mk(1,0,0,0,0,1,2'b00,2'b01,3'b000,0,0);
        C_SW    = mk(0,1,0,0,0,1,2'b00,2'b00,3'b001,0,0);
        C_ADD   = mk(1,0,0,0,0,0,2'b10,2'b00,3'b000,0,0);
        C_BEQ   = mk(0,0,1,0,0,0,2'b01,2'b00,3'b010,0,0);
        C_JAL   = mk(1,0,0,1,0,0,2'b00,2'b10,3'b011,0,0);
        C_JALR  = mk(1,0,0,1,1,1,2'b00,2'b10,3'b000,0,0);
        C_LUI   = mk(1,0,0,0,0,0,2'b00,2'b11,3'b100,0,0);
        C_AUIPC = mk(1,0,0,0,0,1,2'b00,2'b00,3'b100,0,0);
        C_ILL   = mk(0,0,0,0,0,0,2'b00,2'b00,3'b000,0,1);
`ifdef ZBB_DECODE_EN
        C_CLZ   = mk(1,0,0,0,0,0,2'b10,2'b00,3'b000,1,0);
`else
        C_CLZ   = C_ILL;
`endif

        reset = 1'b1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 0;
        exp_ctrl_in = '0;
        idle(0);
        idle(0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_ctrl", 32'(out_ctrl), 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        reset = 1'b0;

        // addi x1,x0,5 visible one edge after acceptance
        drive(1, 32'h00500093, 32'h100, C_ADDI, 0, 0);
        chk("addi_out_valid", 32'(out_valid), 32'h1);
        chk("addi_level", 32'(level), 32'h1);
        chk("addi_ctrl", 32'(out_ctrl), 32'(C_ADDI));
        idle(1);

        // fill to DEPTH, then full queue refuses input while popping
        drive(1, 32'h00012083, 32'h200, C_LW,  0, 0);
        drive(1, 32'h00112023, 32'h204, C_SW,  0, 0);
        drive(1, 32'h002081b3, 32'h208, C_ADD, 0, 0);
        drive(1, 32'h00208463, 32'h20c, C_BEQ, 0, 0);
        chk("full_level", 32'(level), 32'h4);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        drive(1, 32'h00500093, 32'h210, C_ADDI, 1, 0);
        chk("pop_level", 32'(level), 32'h3);
        chk("pop_in_ready", 32'(in_ready), 32'h1);
        repeat (3) idle(1);
        chk("drain_level", 32'(level), 32'h0);

        // steady push+pop at level 2 across a pointer wrap
        drive(1, 32'h008000ef, 32'h300, C_JAL,  0, 0);
        drive(1, 32'h000080e7, 32'h304, C_JALR, 0, 0);
        ss_instr = '{32'h123450b7, 32'h00001097, 32'h00311093, 32'h00500093};
        ss_ctrl  = '{C_LUI, C_AUIPC, C_ADDI, C_ADDI};
        for (int k = 0; k < 8; k++) begin
            drive(1, ss_instr[k % 4], 32'h400 + 32'(k * 4), ss_ctrl[k % 4], 1, 0);
            chk("ss_level", 32'(level), 32'h2);
        end
        repeat (2) idle(1);
        chk("ss_drain_level", 32'(level), 32'h0);

        // flush with an illegal input pending: dropped, counter untouched
        drive(1, 32'h00012083, 32'h500, C_LW,  0, 0);
        drive(1, 32'h00112023, 32'h504, C_SW,  0, 0);
        drive(1, 32'h002081b3, 32'h508, C_ADD, 0, 0);
        chk("pre_flush_level", 32'(level), 32'h3);
        drive(1, 32'hffffffff, 32'h50c, C_ILL, 1, 1);
        chk("flush_level", 32'(level), 32'h0);
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        chk("flush_count", 32'(illegal_count), 32'h0);
        idle(1);
        chk("post_flush_level", 32'(level), 32'h0);

        // clz x1,x2: Zbb decode or illegal depending on build
        drive(1, 32'h60011093, 32'h600, C_CLZ, 0, 0);
`ifdef ZBB_DECODE_EN
        chk("clz_count", 32'(illegal_count), 32'h0);
        chk("clz_zbb", 32'(out_ctrl.zbb), 32'h1);
`else
        chk("clz_count", 32'(illegal_count), 32'h1);
        chk("clz_illegal", 32'(out_ctrl.illegal), 32'h1);
`endif

        // mid-operation reset clears everything
        drive(1, 32'h008000ef, 32'h700, C_JAL, 0, 0);
        chk("pre_rst_level", 32'(level), 32'h2);
        reset = 1'b1;
        idle(0);
        chk("mrst_level", 32'(level), 32'h0);
        chk("mrst_in_ready", 32'(in_ready), 32'h0);
        chk("mrst_out_valid", 32'(out_valid), 32'h0);
        chk("mrst_out_ctrl", 32'(out_ctrl), 32'h0);
        chk("mrst_out_instr", out_instr, 32'h0);
        chk("mrst_out_pc", out_pc, 32'h0);
        chk("mrst_count", 32'(illegal_count), 32'h0);
        reset = 1'b0;
        idle(0);
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);

        // saturating illegal counter with CNT_W=2
        ill_exp = '{1, 2, 3, 3, 3};
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'hffffffff, 32'h800 + 32'(k * 4), C_ILL, 1, 0);
            chk("sat_count", 32'(illegal_count), 32'(ill_exp[k]));
            chk("sat_ctrl", 32'(out_ctrl), 32'(C_ILL));
        end
        drive(1, 32'h00000010, 32'h900, C_ILL, 1, 0);
        drive(1, 32'h0000007f, 32'h904, C_ILL, 1, 0);
        chk("sat_hold", 32'(illegal_count), 32'h3);
        repeat (2) idle(1);
        chk("final_level", 32'(level), 32'h0);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_queue_stage.md
# decode_queue_stage

Registered decode stage for the pipelined RV32I core. It decodes each fetched instruction into a packed control bundle and buffers it with its PC in a DEPTH-entry FIFO. The FIFO sits between fetch and execute and uses valid/ready handshakes on both sides, so a stalled execute stage does not block fetch until the FIFO is full. It extends the combinational main decoder with JALR/LUI/AUIPC, illegal-instruction detection, flush, and an illegal-instruction counter.

## Interface
- XLEN, 32: PC width.
- DEPTH, 4: queue entries; power of two, ≥2.
- CNT_W, 8: width of the saturating illegal-instruction counter.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts; = !reset && level < DEPTH.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  discard all queued entries and the current input.
- out_valid  out  1  head entry valid (level != 0).
- out_ready  in  1  execute consumes head.
- out_ctrl  out  $bits(ctrl_t)  decoded head bundle.
- out_instr  out  32  head raw instruction.
- out_pc  out  XLEN  head PC.
- level  out  $clog2(DEPTH)+1  occupancy.
- illegal_count  out  CNT_W  number of accepted illegal instructions.

## Operation
- ctrl_t fields: reg_write, mem_write, branch, jump, jalr, alu_src, alu_op[1:0], result_src[1:0] (00 ALU, 01 mem, 10 PC+4, 11 imm), imm_src[2:0] (000 I, 001 S, 010 B, 011 J, 100 U), zbb, illegal.
- Decoding by opcode. Any field not listed is 0.
  - 0000011 load: reg_write, alu_src, result_src 01.
  - 0100011 store: mem_write, alu_src, imm_src 001.
  - 0110011 R-type: reg_write, alu_op 10.
  - 0010011 I-ALU: reg_write, alu_src, alu_op 10.
  - 1100011 branch: branch, alu_op 01, imm_src 010.
  - 1101111 jal: reg_write, jump, result_src 10, imm_src 011.
  - 1100111 jalr: reg_write, jump, jalr, alu_src, result_src 10.
  - 0110111 lui: reg_write, result_src 11, imm_src 100.
  - 0010111 auipc: reg_write, alu_src, imm_src 100.
- Illegal conditions: instr[1:0] != 11, an unlisted opcode, or a Zbb encoding when the Zbb feature is compiled out.
  - An illegal instruction is still enqueued: illegal=1 and every other ctrl bit is 0.
- Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready && !flush.
- Push and pop in the same cycle leave level unchanged. FIFO order is preserved and the pointers wrap modulo DEPTH.
- flush (takes priority over push and pop): pointers and level go to 0 at the next edge. The same-cycle input is dropped. illegal_count is unchanged.
- illegal_count increments on each push with illegal=1, saturates at 2^CNT_W-1, and is cleared only by reset.

## Timing
- Latency: an input accepted at edge N is visible on out_* after edge N when the queue was empty. There is no combinational in→out path.
- in_ready depends only on registered level and reset, never on out_ready. A full queue does not accept input in a cycle where it pops.
- out_* is driven from the head storage entry. Its contents are don't-care when out_valid=0, except right after reset.
- Reset, including mid-operation: level=0, out_valid=0, in_ready=0 while reset is high and 1 afterwards, illegal_count=0, storage cleared, so out_ctrl/out_instr/out_pc=0.

## Configuration
- ZBB_DECODE_EN defined: for opcode 0010011 with funct3=001 and imm12 ∈ {0x600 clz, 0x601 ctz, 0x602 cpop}, set zbb=1, reg_write=1, alu_op=10, alu_src=0.
- ZBB_DECODE_EN undefined: the same encodings are illegal. The zbb field still exists and is always 0.

## Structure
- decode_pkg holds:
  - opcode localparams;
  - the ctrl_t packed struct;
  - the result_src and imm_src encodings;
  - the Zbb imm12 constants.
- Sub-module rv_ctrl_decoder: purely combinational, instr → ctrl_t, and contains the ZBB_DECODE_EN conditional. decode_queue_stage instantiates it on in_instr and holds the FIFO, the counter and the flush logic.

## Test plan
- Reset, push addi x1,x0,5 (0x00500093): next cycle out_valid=1, level=1, reg_write=1, alu_src=1, alu_op=10, imm_src=000, result_src=00.
- DEPTH=4, out_ready=0, push 4 instructions: in_ready=0 after the 4th edge, level=4. One pop gives in_ready=1 next cycle; the 4 entries drain in push order.
- level=2 with push and pop in the same cycle: level stays 2, head advances to the second entry, the new entry lands at the tail, and the pointers wrap correctly after 8 such cycles.
- level=3, flush=1, in_valid=1: next cycle level=0, out_valid=0, the input is not enqueued, illegal_count is unchanged.
- CNT_W=2, push 0xFFFFFFFF five times: each entry has out_ctrl.illegal=1 and all other ctrl bits 0; illegal_count reads 1,2,3,3,3.
- Push clz x1,x2 (0x60011093): with ZBB_DECODE_EN, zbb=1, alu_src=0, reg_write=1; without it, illegal=1 and illegal_count increments.
